// File: rtl/rst_ctrl_pkg.sv
// rst_ctrl_pkg: shared FSM state encoding and reset-cause bit positions.
package rst_ctrl_pkg;
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2
  } state_e;
  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_EXT  = 1;
  localparam int CAUSE_SW   = 2;
  localparam int CAUSE_WDOG = 3;
endpackage

// File: rtl/rst_sync2.sv
// rst_sync2: two-flop synchronizer for an asynchronous active-low reset pin, clears to 0.
module rst_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] r_sync;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_sync <= '0;
    else r_sync <= {r_sync[0], d_i};
  assign q_o = r_sync[1];
endmodule

// File: rtl/rst_ctrl.sv
// rst_ctrl: merges POR, external, software and watchdog resets into one stretched
// active-low system reset and records a sticky reset cause.
module rst_ctrl
  import rst_ctrl_pkg::*;
#(
  parameter int STRETCH_CYCLES = 16,
  parameter int CNT_W          = $clog2(STRETCH_CYCLES)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       test_mode_i,
  input  logic       ext_rst_ni,
  input  logic       sw_rst_req_i,
  input  logic       wdog_bite_i,
  input  logic       cause_clr_i,
  output logic       rst_no,
  output logic       busy_o,
  output logic [3:0] cause_o
);
  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_cause, w_set;
  logic             w_ext_sync, w_ext_active, w_level, w_last, w_clr;

  rst_sync2 u_ext_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (ext_rst_ni),
    .q_o    (w_ext_sync)
  );

  assign w_ext_active = ~w_ext_sync;
  assign w_level      = w_ext_active | wdog_bite_i;
  assign w_last       = r_cnt == CNT_W'(STRETCH_CYCLES - 1);
  assign w_clr        = cause_clr_i & (r_state == RUN);

  always_comb begin
    w_set             = '0;
    w_set[CAUSE_EXT]  = w_ext_active;
    w_set[CAUSE_SW]   = sw_rst_req_i;
    w_set[CAUSE_WDOG] = wdog_bite_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_state            <= HOLD;
      r_cnt              <= '0;
      r_cause            <= '0;
      r_cause[CAUSE_POR] <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cause <= (w_clr ? '0 : r_cause) | w_set;
    end

  // Level sources dominate; a sw request restarts the stretch from zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      HOLD:    w_state_nxt = w_level ? HOLD : STRETCH;
      STRETCH: begin
        w_state_nxt = w_level ? HOLD : (!sw_rst_req_i && w_last) ? RUN : STRETCH;
        w_cnt_nxt   = (w_level || sw_rst_req_i || w_last) ? '0 : r_cnt + CNT_W'(1);
      end
      RUN:     w_state_nxt = w_level ? HOLD : sw_rst_req_i ? STRETCH : RUN;
      default: w_state_nxt = HOLD;
    endcase
  end

  always_comb begin
    rst_no = test_mode_i ? rst_ni : (r_state == RUN);
    busy_o = r_state != RUN;
  end

  assign cause_o = r_cause;
endmodule

// File: tb/tb_rst_ctrl.sv
// tb_rst_ctrl: randomized scoreboard bench; the model tracks the edge at which reset releases.
module tb_rst_ctrl;
  localparam int S = 16;

  logic       clk = 1'b0, rst_ni = 1'b0, test_mode = 1'b0, ext_rst_ni = 1'b1;
  logic       sw = 1'b0, wdog = 1'b0, clr = 1'b0;
  logic       rst_no, busy;
  logic [3:0] cause;

  rst_ctrl #(.STRETCH_CYCLES(S)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .test_mode_i  (test_mode),
    .ext_rst_ni   (ext_rst_ni),
    .sw_rst_req_i (sw),
    .wdog_bite_i  (wdog),
    .cause_clr_i  (clr),
    .rst_no       (rst_no),
    .busy_o       (busy),
    .cause_o      (cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         run;
    logic [3:0] cause;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_cmp = 0, n_bad = 0;
  int         cyc = 0, run_at;
  bit         m_run, s1, s2, ext_act, level, exp_rst;
  logic [3:0] m_cause;

  function automatic void m_reset();
    run_at  = 1 << 30;
    m_run   = 1'b0;
    s1      = 1'b0;
    s2      = 1'b0;
    m_cause = 4'b0001;
  endfunction

  initial m_reset();
  always @(negedge rst_ni) m_reset();

  // Reset is released at edge run_at; a level source pushes it to S+1 edges past the
  // last active edge, a sw request to S edges past the request.
  always @(posedge clk) begin
    cyc++;
    if (!rst_ni) m_reset();
    else begin
      ext_act = !s2;
      level   = ext_act || wdog;
      m_cause = ((m_run && clr) ? 4'b0000 : m_cause) | {wdog, sw, ext_act, 1'b0};
      if (level) run_at = cyc + 1 + S;
      else if (sw) run_at = cyc + S;
      m_run = cyc >= run_at;
      s2    = s1;
      s1    = ext_rst_ni;
    end
    sb.push_back('{m_run, m_cause});
  end

  always @(negedge clk)
    if (sb.size() > 0) begin
      e       = sb.pop_front();
      exp_rst = test_mode ? rst_ni : e.run;
      n_cmp++;
      if ({rst_no, busy, cause} !== {exp_rst, !e.run, e.cause}) begin
        n_bad++;
        $display("FAIL sb t=%0t got rst_no=%b busy=%b cause=%b want rst_no=%b busy=%b cause=%b",
                 $time, rst_no, busy, cause, exp_rst, !e.run, e.cause);
      end
    end

  task automatic check(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int n, wd, ex;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!rst_no && n < 100);
    check("por_lat", n, S + 3);
    repeat (3) tick();
    sw = 1'b1;
    tick();
    sw = 1'b0;
    n = 0;
    while (!rst_no && n < 100) begin n++; tick(); end
    check("sw_lat", n, S);
    clr = 1'b1;
    sw  = 1'b1;
    tick();
    clr = 1'b0;
    sw  = 1'b0;
    check("clr_vs_sw", int'(cause), 4'b0100);
    repeat (S + 2) tick();
    sw = 1'b1;
    tick();
    sw = 1'b0;
    repeat (8) tick();
    ext_rst_ni = 1'b0;
    tick();
    ext_rst_ni = 1'b1;
    repeat (S + 8) tick();
    check("ext_cause", int'(cause[1]), 1);
    wdog = 1'b1;
    repeat (10) tick();
    clr  = 1'b1;
    tick();
    clr  = 1'b0;
    wdog = 1'b0;
    repeat (S + 3) tick();
    check("wdog_cause", int'(cause[3]), 1);
    wd = 0;
    ex = 0;
    for (int i = 0; i < 800; i++) begin
      sw  = $urandom_range(24) == 0;
      clr = $urandom_range(9) == 0;
      if (wd == 0 && $urandom_range(70) == 0) wd = $urandom_range(12, 1);
      if (ex == 0 && $urandom_range(70) == 0) ex = $urandom_range(5, 1);
      wdog       = wd > 0;
      ext_rst_ni = !(ex > 0);
      if (wd > 0) wd--;
      if (ex > 0) ex--;
      tick();
      if ($urandom_range(299) == 0) begin
        @(negedge clk);
        #1 rst_ni = 1'b0;
        @(posedge clk);
        #1 rst_ni = 1'b1;
      end
    end
    {sw, clr, wdog, ext_rst_ni} = 4'b0001;
    repeat (S + 5) tick();
    test_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      rst_ni = 1'($urandom_range(1));
      wdog   = 1'($urandom_range(1));
      #1 check("tm_follow", int'(rst_no), int'(rst_ni));
    end
    @(negedge clk);
    #1;
    rst_ni    = 1'b1;
    wdog      = 1'b0;
    test_mode = 1'b0;
    repeat (S + 8) tick();
    check("final_run", int'(rst_no), 1);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
